// File: rtl/oled_refresh_scheduler_if.sv
// Handshake bundle between the OLED refresh scheduler and the init/write engines and host.
interface oled_refresh_scheduler_if;
  logic       init_done_sig;
  logic       write_done_sig;
  logic       reinit_req;
  logic       init_start_sig;
  logic       write_start_sig;
  logic [3:0] page_idx;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  modport master (
    input  init_done_sig, write_done_sig, reinit_req,
    output init_start_sig, write_start_sig, page_idx, busy, frame_done, timeout_err
  );

  modport slave (
    output init_done_sig, write_done_sig, reinit_req,
    input  init_start_sig, write_start_sig, page_idx, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/oled_refresh_scheduler.sv
// OLED IIC display sequencer: one init pass, then periodic page-by-page refresh,
// with a done-timeout watchdog that forces re-init and a deferred host re-init request.
//
//   state   | meaning
//   INIT_GO | one-cycle launch of an init pass
//   INIT    | init engine running, waiting for init_done
//   WRITE   | write engine sending page_q, waiting for write_done
//   GAP     | one idle cycle between starts so the engines can rearm
//   WAIT    | refresh interval between frames
module oled_refresh_scheduler #(
  parameter int PAGES          = 4,
  parameter int REFRESH_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                         CLOCK,
  input logic                         RST_n,
  oled_refresh_scheduler_if.master    sched
);

  localparam int TMR_MAX = (REFRESH_CYCLES > TIMEOUT_CYCLES) ? REFRESH_CYCLES : TIMEOUT_CYCLES;
  localparam int TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TW-1:0] REFRESH_LOAD = TW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_PAGE    = 4'(PAGES - 1);

  typedef enum logic [2:0] {
    S_INIT_GO,
    S_INIT,
    S_WRITE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    page_q, page_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_q, pend_d;
  logic          init_start_q, write_start_q, busy_q, frame_done_q, timeout_err_q;

  logic          frame_end;
  logic          tmo;
  logic          pend_now;
  logic          expired;
  logic          entering;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_INIT_GO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    frame_end = 1'b0;
    tmo       = 1'b0;
    pend_now  = pend_q | sched.reinit_req;
    expired   = (tmr_q == '0);

    case (state_q)
      S_INIT_GO: state_d = S_INIT;
      S_INIT: begin
        if (sched.init_done_sig) begin
          page_d  = '0;
          state_d = S_GAP;
        end else if (expired) begin
          tmo     = 1'b1;
          page_d  = '0;
          state_d = S_INIT_GO;
        end
      end
      S_WRITE: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (sched.write_done_sig) begin
          if (page_q == LAST_PAGE) begin
            frame_end = 1'b1;
            page_d    = '0;
            state_d   = pend_now ? S_INIT_GO : S_WAIT;
          end else begin
            page_d  = page_q + 4'd1;
            state_d = S_GAP;
          end
        end else if (expired) begin
          tmo     = 1'b1;
          page_d  = '0;
          state_d = S_INIT_GO;
        end
      end
      S_GAP: state_d = S_WRITE;
      S_WAIT: begin
        if (pend_now) begin
          state_d = S_INIT_GO;
        end else if (expired) begin
          state_d = S_WRITE;
        end
      end
      default: state_d = S_INIT_GO;
    endcase

    entering = (state_d != state_q);

    // One down-counter serves both the refresh interval and the done watchdog.
    if (entering) begin
      tmr_d = (state_d == S_WAIT) ? REFRESH_LOAD : TIMEOUT_LOAD;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end else begin
      tmr_d = tmr_q;
    end

    if (entering && (state_d == S_INIT_GO)) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_now;
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      page_q        <= '0;
      tmr_q         <= '0;
      pend_q        <= 1'b0;
      init_start_q  <= 1'b0;
      write_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      page_q        <= page_d;
      tmr_q         <= tmr_d;
      pend_q        <= pend_d;
      init_start_q  <= (state_d == S_INIT);
      write_start_q <= (state_d == S_WRITE);
      busy_q        <= (state_d == S_INIT) || (state_d == S_WRITE) || (state_d == S_GAP);
      frame_done_q  <= frame_end;
      timeout_err_q <= timeout_err_q | tmo;
    end
  end

  assign sched.init_start_sig  = init_start_q;
  assign sched.write_start_sig = write_start_q;
  assign sched.page_idx        = page_q;
  assign sched.busy            = busy_q;
  assign sched.frame_done      = frame_done_q;
  assign sched.timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_oled_refresh_scheduler.sv
// Directed bench for oled_refresh_scheduler: a cycle table for the first frame,
// then hand-written sequences for re-init, watchdog and async reset corners.
module tb_oled_refresh_scheduler;
  localparam int PAGES   = 4;
  localparam int REFRESH = 20;
  localparam int TIMEOUT = 50;

  logic CLOCK = 1'b0;
  logic RST_n = 1'b0;

  oled_refresh_scheduler_if bus();

  oled_refresh_scheduler #(
    .PAGES(PAGES),
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .CLOCK(CLOCK),
    .RST_n(RST_n),
    .sched(bus)
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;

  // exp = {init_start, write_start, page_idx[3:0], busy, frame_done, timeout_err}
  typedef struct {
    logic       id;
    logic       wd;
    logic       rq;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {bus.init_start_sig, bus.write_start_sig, bus.page_idx,
            bus.busy, bus.frame_done, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic add(input int n, input logic id, input logic wd, input logic rq,
                     input logic is, input logic ws, input logic [3:0] pg,
                     input logic bz, input logic fd);
    vec_t v;
    v.id  = id;
    v.wd  = wd;
    v.rq  = rq;
    v.exp = {is, ws, pg, bz, fd, 1'b0};
    repeat (n) vecs.push_back(v);
  endtask

  // Entered with write_start just risen; engine answers done after 5 samples.
  task automatic do_page(input int pg, input bit last, input bit pulse_rq);
    bit ok;
    ok = 1'b1;
    check("write_start", 32'({bus.write_start_sig, bus.page_idx}), 32'({1'b1, 4'(pg)}));
    for (int i = 1; i <= 4; i++) begin
      if (i == 2 && pulse_rq) bus.reinit_req = 1'b1;
      tick();
      bus.reinit_req = 1'b0;
      if (!(bus.write_start_sig === 1'b1 && bus.page_idx === 4'(pg) && bus.busy === 1'b1)) ok = 1'b0;
    end
    check("page_hold", 32'(ok), 32'(1));
    bus.write_done_sig = 1'b1;
    tick();
    bus.write_done_sig = 1'b0;
    check("write_end", 32'({bus.write_start_sig, bus.frame_done, bus.busy}),
          32'({1'b0, last, !last}));
    if (!last) begin
      tick();
      check("gap_len", 32'({bus.write_start_sig, bus.page_idx}), 32'({1'b1, 4'(pg + 1)}));
    end
  endtask

  // Entered with init_start just risen; a stray write_done is ignored.
  task automatic do_init();
    bit ok;
    ok = 1'b1;
    check("init_start", 32'(bus.init_start_sig), 32'(1));
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) bus.write_done_sig = 1'b1;
      tick();
      bus.write_done_sig = 1'b0;
      if (!(bus.init_start_sig === 1'b1 && bus.write_start_sig === 1'b0)) ok = 1'b0;
    end
    check("init_hold", 32'(ok), 32'(1));
    bus.init_done_sig = 1'b1;
    tick();
    bus.init_done_sig = 1'b0;
    check("init_gap", 32'({bus.init_start_sig, bus.write_start_sig, bus.busy, bus.page_idx}),
          32'({1'b0, 1'b0, 1'b1, 4'd0}));
    tick();
    check("first_write", 32'({bus.write_start_sig, bus.page_idx}), 32'({1'b1, 4'd0}));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    bus.init_done_sig  = 1'b0;
    bus.write_done_sig = 1'b0;
    bus.reinit_req     = 1'b0;

    // First frame, cycle by cycle from reset release.
    add(10, 0, 0, 0, 1, 0, 4'd0, 1, 0);
    add(1,  1, 0, 0, 0, 0, 4'd0, 1, 0);
    for (int p = 0; p < PAGES; p++) begin
      add(5, 0, 0, 0, 0, 1, 4'(p), 1, 0);
      if (p < PAGES - 1) add(1, 0, 1, 0, 0, 0, 4'(p + 1), 1, 0);
      else               add(1, 0, 1, 0, 0, 0, 4'd0, 0, 1);
    end
    add(REFRESH - 1, 0, 0, 0, 0, 0, 4'd0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4'd0, 1, 0);

    repeat (3) @(posedge CLOCK);
    #1;
    check("reset_outs", 32'(outs()), 32'(0));
    @(negedge CLOCK);
    RST_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      bus.init_done_sig  = vecs[k].id;
      bus.write_done_sig = vecs[k].wd;
      bus.reinit_req     = vecs[k].rq;
      tick();
      check($sformatf("vec%0d", k + 1), 32'(outs()), 32'(vecs[k].exp));
    end
    bus.init_done_sig  = 1'b0;
    bus.write_done_sig = 1'b0;
    bus.reinit_req     = 1'b0;

    // Re-init request mid-frame: frame completes, then init instead of refresh wait.
    do_page(0, 1'b0, 1'b0);
    do_page(1, 1'b0, 1'b1);
    do_page(2, 1'b0, 1'b0);
    do_page(3, 1'b1, 1'b0);
    check("reinit_go", 32'({bus.init_start_sig, bus.busy}), 32'({1'b0, 1'b0}));
    tick();
    check("reinit_init", 32'({bus.init_start_sig, bus.busy}), 32'({1'b1, 1'b1}));

    // Hold init until the watchdog's last cycle; done must win.
    ok = 1'b1;
    repeat (TIMEOUT - 1) begin
      tick();
      if (bus.init_start_sig !== 1'b1) ok = 1'b0;
    end
    check("init_hold_wd", 32'(ok), 32'(1));
    bus.init_done_sig = 1'b1;
    tick();
    bus.init_done_sig = 1'b0;
    check("done_beats_wd", 32'({bus.init_start_sig, bus.busy, bus.timeout_err}),
          32'({1'b0, 1'b1, 1'b0}));
    tick();
    check("post_init_write", 32'({bus.write_start_sig, bus.page_idx}), 32'({1'b1, 4'd0}));

    // Pending request was consumed: this frame ends in a normal refresh wait.
    do_page(0, 1'b0, 1'b0);
    do_page(1, 1'b0, 1'b0);
    do_page(2, 1'b0, 1'b0);
    do_page(3, 1'b1, 1'b0);
    ok = 1'b1;
    repeat (REFRESH - 1) begin
      tick();
      if (bus.init_start_sig !== 1'b0 || bus.write_start_sig !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("wait_idle", 32'(ok), 32'(1));
    tick();
    check("refresh_restart", 32'({bus.write_start_sig, bus.page_idx, bus.busy}),
          32'({1'b1, 4'd0, 1'b1}));

    // Write engine stalls on page 2: watchdog fires and forces re-init.
    do_page(0, 1'b0, 1'b0);
    do_page(1, 1'b0, 1'b0);
    ok = 1'b1;
    repeat (TIMEOUT - 1) begin
      tick();
      if (bus.write_start_sig !== 1'b1 || bus.timeout_err !== 1'b0 || bus.page_idx !== 4'd2) ok = 1'b0;
    end
    check("wd_hold", 32'(ok), 32'(1));
    tick();
    check("wd_expire", 32'({bus.timeout_err, bus.write_start_sig, bus.init_start_sig, bus.busy, bus.page_idx}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 4'd0}));
    tick();
    check("wd_reinit", 32'({bus.init_start_sig, bus.timeout_err}), 32'({1'b1, 1'b1}));
    do_init();

    // Asynchronous reset in the middle of page 2.
    do_page(0, 1'b0, 1'b0);
    do_page(1, 1'b0, 1'b0);
    tick();
    tick();
    #2;
    RST_n = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'(0));
    @(negedge CLOCK);
    RST_n = 1'b1;
    tick();
    check("restart_init", 32'({bus.init_start_sig, bus.busy, bus.timeout_err}),
          32'({1'b1, 1'b1, 1'b0}));
    do_init();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
